// File: rtl/acc_fp_sat.sv
// Block accumulator for the S(11.10) adder stream: sums N_ACC accepted samples at full
// resolution, requantizes to S(NB_OUT.NBF_OUT) with optional round-half-up and saturation.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no partial block, acc = 0, count = 0
// ST_ACC  | partial block in progress
// ST_WAIT | block result held on o_data until handshake
module acc_fp_sat #(
   parameter int NB_IN   = 11,
   parameter int NBF_IN  = 10,
   parameter int N_ACC   = 8,
   parameter int NB_OUT  = 10,
   parameter int NBF_OUT = 8,
   parameter int ROUND   = 1
) (
   input  logic                     i_clock,
   input  logic                     i_rst_n,
   input  logic signed [NB_IN-1:0]  i_data,
   input  logic                     i_valid,
   output logic                     o_in_ready,
   input  logic                     i_clear,
   output logic signed [NB_OUT-1:0] o_data,
   output logic                     o_valid,
   input  logic                     i_out_ready,
   output logic                     o_sat
);

   localparam int NB_ACC    = NB_IN + $clog2(N_ACC);
   localparam int CW        = (N_ACC > 1) ? $clog2(N_ACC) : 1;
   localparam int SH        = NBF_IN - NBF_OUT;
   localparam int RND_SHIFT = (SH > 0) ? SH - 1 : 0;

   localparam logic [CW-1:0]          LAST    = CW'(N_ACC - 1);
   localparam logic signed [NB_ACC:0] RND_K   = (ROUND == 1 && SH > 0) ?
                                                ((NB_ACC+1)'(1) << RND_SHIFT) : '0;
   localparam logic signed [NB_ACC:0] SAT_MAX = (NB_ACC+1)'((2**(NB_OUT-1)) - 1);
   localparam logic signed [NB_ACC:0] SAT_MIN = (NB_ACC+1)'(-(2**(NB_OUT-1)));

   typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_WAIT} state_t;

   state_t                    state, state_nxt;
   logic signed [NB_ACC-1:0]  acc;
   logic [CW-1:0]             count;
   logic                      accept;
   logic                      last;
   logic signed [NB_ACC-1:0]  din_ext;
   logic signed [NB_ACC-1:0]  sum;
   logic signed [NB_ACC:0]    sum_wide;
   logic signed [NB_ACC:0]    rnd_sum;
   logic signed [NB_ACC:0]    q;
   logic signed [NB_OUT-1:0]  q_data;
   logic                      q_sat;

   // acc and count are zero in IDLE, so one adder serves both the first and later samples
   assign accept   = i_valid & o_in_ready;
   assign last     = (count == LAST);
   assign din_ext  = NB_ACC'(i_data);
   assign sum      = acc + din_ext;
   assign sum_wide = (NB_ACC+1)'(sum);
   assign rnd_sum  = sum_wide + RND_K;
   assign q        = rnd_sum >>> SH;

   always_comb begin
      q_data = q[NB_OUT-1:0];
      q_sat  = 1'b0;
      if (q > SAT_MAX) begin
         q_data = SAT_MAX[NB_OUT-1:0];
         q_sat  = 1'b1;
      end else if (q < SAT_MIN) begin
         q_data = SAT_MIN[NB_OUT-1:0];
         q_sat  = 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (i_clear) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_ACC: if (accept) state_nxt = last ? ST_WAIT : ST_ACC;
            ST_WAIT:         if (i_out_ready) state_nxt = ST_IDLE;
            default:         state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_in_ready = (state != ST_WAIT);
      o_valid    = (state == ST_WAIT);
   end

   // the result is captured on the last accepted sample; acc/count clear at the same edge
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc    <= '0;
         count  <= '0;
         o_data <= '0;
         o_sat  <= 1'b0;
      end else if (i_clear) begin
         acc    <= '0;
         count  <= '0;
         o_sat  <= 1'b0;
      end else if (accept) begin
         if (last) begin
            acc    <= '0;
            count  <= '0;
            o_data <= q_data;
            o_sat  <= q_sat;
         end else begin
            acc    <= sum;
            count  <= count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_acc_fp_sat.sv
// Self-checking bench for acc_fp_sat: default build, a truncating build and an N_ACC=1 build
// share stimulus; expected block results are queued when driven and popped on output.
module tb_acc_fp_sat;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] din = '0;
   logic        valid = 1'b0;
   logic        clear = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, dv, sat;
   logic [9:0]  dout;
   logic        t_in_ready, t_valid, t_sat;
   logic [9:0]  t_data;
   logic        n_in_ready, n_valid, n_sat;
   logic [9:0]  n_data;

   int checks = 0;
   int failures = 0;
   logic [10:0] exp_q[$];
   logic [10:0] exp_t[$];
   logic [10:0] exp_n[$];

   always #5 clk = ~clk;

   acc_fp_sat u_dut (
      .i_clock(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(valid), .o_in_ready(in_ready),
      .i_clear(clear), .o_data(dout), .o_valid(dv), .i_out_ready(out_ready), .o_sat(sat));

   acc_fp_sat #(.ROUND(0)) u_trunc (
      .i_clock(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(valid), .o_in_ready(t_in_ready),
      .i_clear(clear), .o_data(t_data), .o_valid(t_valid), .i_out_ready(out_ready), .o_sat(t_sat));

   acc_fp_sat #(.N_ACC(1)) u_n1 (
      .i_clock(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(valid), .o_in_ready(n_in_ready),
      .i_clear(clear), .o_data(n_data), .o_valid(n_valid), .i_out_ready(out_ready), .o_sat(n_sat));

   // reference requantizer for the default build: SH=2, S(10.8) output range
   function automatic logic [10:0] model(input int sum, input bit rnd);
      int q;
      q = rnd ? ((sum + 2) >>> 2) : (sum >>> 2);
      if (q > 511)  return {1'b1, 10'h1FF};
      if (q < -512) return {1'b1, 10'h200};
      return {1'b0, q[9:0]};
   endfunction

   task automatic send(input logic [10:0] d);
      int n = 0;
      din = d;
      valid = 1'b1;
      while (!in_ready && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout o_in_ready=%0b required=1", in_ready);
      end
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic send_n(input logic [10:0] d, input int n);
      for (int i = 0; i < n; i++) send(d);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!dv && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      if (!dv) begin
         checks++; failures++;
         $display("FAIL wait_valid_timeout o_valid=%0b required=1", dv);
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({dv, sat, dout} !== 12'h000) begin
         failures++;
         $display("FAIL reset_outputs got v=%0b s=%0b d=%h required 0/0/000", dv, sat, dout);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got %0b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      logic [10:0] e;
      pulse_clear();
      send_n(11'h080, 8);
      exp_q.push_back(model(8 * 128, 1'b1));
      checks++;
      if (dv !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL basic_latency got v=%0b rdy=%0b required v=1 rdy=0", dv, in_ready);
      end
      e = exp_q.pop_front();
      checks++;
      if ({sat, dout} !== e || e !== 11'h100) begin
         failures++;
         $display("FAIL basic_data got s=%0b d=%h required s=0 d=100", sat, dout);
      end
      handshake();
      checks++;
      if (dv !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL basic_handshake got v=%0b rdy=%0b required v=0 rdy=1", dv, in_ready);
      end
   endtask

   task automatic test_saturation();
      logic [10:0] e;
      send_n(11'h200, 8);
      exp_q.push_back(model(8 * 512, 1'b1));
      wait_valid();
      e = exp_q.pop_front();
      checks++;
      if ({sat, dout} !== e) begin
         failures++;
         $display("FAIL sat_pos got s=%0b d=%h required s=%0b d=%h", sat, dout, e[10], e[9:0]);
      end
      handshake();
      send_n(11'h400, 8);
      exp_q.push_back(model(8 * -1024, 1'b1));
      wait_valid();
      e = exp_q.pop_front();
      checks++;
      if ({sat, dout} !== e) begin
         failures++;
         $display("FAIL sat_neg got s=%0b d=%h required s=%0b d=%h", sat, dout, e[10], e[9:0]);
      end
      handshake();
   endtask

   task automatic test_rounding();
      logic [10:0] first[4] = '{11'h003, 11'h002, 11'h7FE, 11'h7FD};
      logic [9:0]  rnd_e[4] = '{10'h001, 10'h001, 10'h000, 10'h3FF};
      logic [9:0]  trn_e[4] = '{10'h000, 10'h000, 10'h3FF, 10'h3FF};
      logic [10:0] e, et;
      pulse_clear();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, rnd_e[i]});
         exp_t.push_back({1'b0, trn_e[i]});
         send(first[i]);
         send_n(11'h000, 7);
         wait_valid();
         e  = exp_q.pop_front();
         et = exp_t.pop_front();
         checks++;
         if ({sat, dout} !== e) begin
            failures++;
            $display("FAIL round_%0d got s=%0b d=%h required s=%0b d=%h",
                     i, sat, dout, e[10], e[9:0]);
         end
         checks++;
         if ({t_valid, t_sat, t_data} !== {1'b1, et}) begin
            failures++;
            $display("FAIL trunc_%0d got v=%0b s=%0b d=%h required v=1 s=%0b d=%h",
                     i, t_valid, t_sat, t_data, et[10], et[9:0]);
         end
         handshake();
      end
   endtask

   task automatic test_backpressure();
      logic [10:0] e;
      send_n(11'h080, 8);
      exp_q.push_back(model(8 * 128, 1'b1));
      din = 11'h3FF;
      valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({dv, in_ready, sat, dout} !== {2'b10, 11'h100}) begin
            failures++;
            $display("FAIL stall_%0d got v=%0b rdy=%0b s=%0b d=%h required v=1 rdy=0 s=0 d=100",
                     i, dv, in_ready, sat, dout);
         end
      end
      valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({sat, dout} !== e) begin
         failures++;
         $display("FAIL stall_data got s=%0b d=%h required s=%0b d=%h", sat, dout, e[10], e[9:0]);
      end
      handshake();
      send_n(11'h010, 8);
      exp_q.push_back(model(8 * 16, 1'b1));
      wait_valid();
      e = exp_q.pop_front();
      checks++;
      if ({sat, dout} !== e) begin
         failures++;
         $display("FAIL after_stall got s=%0b d=%h required s=%0b d=%h", sat, dout, e[10], e[9:0]);
      end
      handshake();
   endtask

   task automatic test_clear();
      logic [10:0] e;
      send_n(11'h100, 5);
      clear = 1'b1;
      valid = 1'b1;
      din = 11'h200;
      @(posedge clk); #1;
      clear = 1'b0;
      valid = 1'b0;
      send_n(11'h080, 7);
      checks++;
      if (dv !== 1'b0) begin
         failures++;
         $display("FAIL clear_early_valid got %0b required 0", dv);
      end
      send(11'h080);
      exp_q.push_back(model(8 * 128, 1'b1));
      checks++;
      if (dv !== 1'b1) begin
         failures++;
         $display("FAIL clear_block_valid got %0b required 1", dv);
      end
      e = exp_q.pop_front();
      checks++;
      if ({sat, dout} !== e) begin
         failures++;
         $display("FAIL clear_block_data got s=%0b d=%h required s=%0b d=%h", sat, dout, e[10], e[9:0]);
      end
      handshake();
      send_n(11'h200, 8);
      wait_valid();
      pulse_clear();
      checks++;
      if ({dv, sat, in_ready, dout} !== {3'b001, 10'h1FF}) begin
         failures++;
         $display("FAIL clear_wait got v=%0b s=%0b rdy=%0b d=%h required v=0 s=0 rdy=1 d=1ff",
                  dv, sat, in_ready, dout);
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] e;
      send_n(11'h080, 8);
      wait_valid();
      handshake();
      send_n(11'h080, 3);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({dv, sat, in_ready, dout} !== {3'b001, 10'h000}) begin
         failures++;
         $display("FAIL async_reset got v=%0b s=%0b rdy=%0b d=%h required v=0 s=0 rdy=1 d=000",
                  dv, sat, in_ready, dout);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      send_n(11'h7C0, 8);
      exp_q.push_back(model(8 * -64, 1'b1));
      wait_valid();
      e = exp_q.pop_front();
      checks++;
      if ({sat, dout} !== e) begin
         failures++;
         $display("FAIL post_reset got s=%0b d=%h required s=%0b d=%h", sat, dout, e[10], e[9:0]);
      end
      handshake();
   endtask

   task automatic test_n1();
      logic [10:0] vals[4] = '{11'h080, 11'h200, 11'h7FF, 11'h400};
      logic [10:0] e;
      pulse_clear();
      for (int i = 0; i < 4; i++) begin
         exp_n.push_back(model(int'($signed(vals[i])), 1'b1));
         din = vals[i];
         valid = 1'b1;
         @(posedge clk); #1;
         valid = 1'b0;
         e = exp_n.pop_front();
         checks++;
         if ({n_valid, n_in_ready, n_sat, n_data} !== {2'b10, e}) begin
            failures++;
            $display("FAIL n1_%0d got v=%0b rdy=%0b s=%0b d=%h required v=1 rdy=0 s=%0b d=%h",
                     i, n_valid, n_in_ready, n_sat, n_data, e[10], e[9:0]);
         end
         handshake();
         checks++;
         if (n_valid !== 1'b0) begin
            failures++;
            $display("FAIL n1_release_%0d got v=%0b required 0", i, n_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_rounding();
      test_backpressure();
      test_clear();
      test_reset_mid();
      test_n1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
